// File: rtl/stage_sequencer_pkg.sv
// Shared types for the stage sequencer: FSM states, config field codes and the per-stage record.
package stage_sequencer_pkg;

  localparam int REC_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_BURN     = 3'd2,
    ST_SEPARATE = 3'd3,
    ST_DONE     = 3'd4,
    ST_FAULT    = 3'd5
  } state_e;

  localparam logic [1:0] FLD_ISP      = 2'd0;
  localparam logic [1:0] FLD_PROP     = 2'd1;
  localparam logic [1:0] FLD_DRY      = 2'd2;
  localparam logic [1:0] FLD_BURNTIME = 2'd3;

  typedef struct packed {
    logic [REC_W-1:0] isp;
    logic [REC_W-1:0] prop_mass;
    logic [REC_W-1:0] dry_mass;
    logic [REC_W-1:0] burntime;
  } stage_rec_t;

endpackage

// File: rtl/stage_sequencer_param_table.sv
// Per-stage parameter register file: one write port, one combinational read port,
// plus the combinational wet mass of the whole stack.
module stage_param_table
  import stage_sequencer_pkg::*;
#(
  parameter int N_STAGES = 3,
  parameter int W        = 64
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         wr_en,
  input  logic [2:0]   wr_stage,
  input  logic [1:0]   wr_field,
  input  logic [W-1:0] wr_data,
  input  logic [2:0]   rd_stage,
  output stage_rec_t   rd_rec,
  output logic [W-1:0] stack_mass
);

  stage_rec_t tbl_q [N_STAGES];
  stage_rec_t tbl_d [N_STAGES];

  always_comb begin
    tbl_d = tbl_q;
    // Out-of-range stage indices never alias onto a real entry.
    if (wr_en && (int'(wr_stage) < N_STAGES)) begin
      for (int i = 0; i < N_STAGES; i++) begin
        if (int'(wr_stage) == i) begin
          case (wr_field)
            FLD_ISP:      tbl_d[i].isp       = REC_W'(wr_data);
            FLD_PROP:     tbl_d[i].prop_mass = REC_W'(wr_data);
            FLD_DRY:      tbl_d[i].dry_mass  = REC_W'(wr_data);
            FLD_BURNTIME: tbl_d[i].burntime  = REC_W'(wr_data);
            default:      ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < N_STAGES; i++) tbl_q[i] <= '0;
    end else begin
      tbl_q <= tbl_d;
    end
  end

  always_comb begin
    rd_rec     = '0;
    stack_mass = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      if (int'(rd_stage) == i) rd_rec = tbl_q[i];
      stack_mass = stack_mass + tbl_q[i].prop_mass[W-1:0] + tbl_q[i].dry_mass[W-1:0];
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Drives one shared velocity engine through every stage: arm, burn, separate, repeat,
// carrying velocity forward and shedding each spent stage's mass.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int N_STAGES        = 3,
  parameter int W               = 64,
  parameter int SEP_CYCLES      = 4,
  parameter int ARM_CYCLES      = 2,
  parameter int MAX_BURN_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         start,
  input  logic         abort,
  input  logic         cfg_we,
  input  logic [2:0]   cfg_stage,
  input  logic [1:0]   cfg_field,
  input  logic [W-1:0] cfg_data,
  input  logic [W-1:0] payload_mass,
  output logic         eng_resetb,
  output logic [W-1:0] eng_isp,
  output logic [W-1:0] eng_initial_weight,
  output logic [W-1:0] eng_prop_weight,
  output logic [W-1:0] eng_burntime,
  output logic [W-1:0] eng_v0,
  input  logic [W-1:0] eng_velocity,
  input  logic         eng_ignition_end,
  output logic [2:0]   stage_idx,
  output logic         busy,
  output logic         sep_pulse,
  output logic         done,
  output logic         fault,
  output logic [W-1:0] final_velocity
);

  localparam int WD_W = $clog2(MAX_BURN_CYCLES + 1);

  state_e          state_q, state_d;
  logic [2:0]      stage_q, stage_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [W-1:0]    total_q, total_d;
  logic [W-1:0]    isp_q, isp_d, initw_q, initw_d, prop_q, prop_d, bt_q, bt_d;
  logic [W-1:0]    v0_q, v0_d, fin_q, fin_d;

  stage_rec_t      rd_rec;
  logic [W-1:0]    stack_mass, sep_mass;
  logic            idle_like, launch, arm_last, sep_last, last_stage;
  logic            burn_end, underflow, load_ops;

  assign idle_like  = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_FAULT);
  assign launch     = idle_like && start && !abort;
  assign arm_last   = (cnt_q == 32'(ARM_CYCLES - 1));
  assign sep_last   = (cnt_q == 32'(SEP_CYCLES - 1));
  assign last_stage = (stage_q == 3'(N_STAGES - 1));
  // The engine is still leaving reset on the first burn cycle, so its flag is not trusted there.
  assign burn_end   = (state_q == ST_BURN) && !abort && eng_ignition_end && (wd_q != '0);
  assign sep_mass   = rd_rec.prop_mass[W-1:0] + rd_rec.dry_mass[W-1:0];
  assign underflow  = sep_mass > total_q;

  // Reading at the next stage index lets operands be registered on the way into ARM.
  assign stage_d = launch ? 3'd0 :
                   ((state_q == ST_SEPARATE) && !abort && sep_last) ? stage_q + 3'd1 :
                   stage_q;

  stage_param_table #(
    .N_STAGES (N_STAGES),
    .W        (W)
  ) u_table (
    .clk        (clk),
    .resetb     (resetb),
    .wr_en      (cfg_we && idle_like),
    .wr_stage   (cfg_stage),
    .wr_field   (cfg_field),
    .wr_data    (cfg_data),
    .rd_stage   (stage_d),
    .rd_rec     (rd_rec),
    .stack_mass (stack_mass)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      total_q <= '0;
      isp_q   <= '0;
      initw_q <= '0;
      prop_q  <= '0;
      bt_q    <= '0;
      v0_q    <= '0;
      fin_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      total_q <= total_d;
      isp_q   <= isp_d;
      initw_q <= initw_d;
      prop_q  <= prop_d;
      bt_q    <= bt_d;
      v0_q    <= v0_d;
      fin_q   <= fin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (launch) begin
          state_d = ST_ARM;
          cnt_d   = '0;
        end
      end
      ST_ARM: begin
        if (abort)         state_d = ST_FAULT;
        else if (arm_last) begin
          state_d = ST_BURN;
          wd_d    = '0;
        end else           cnt_d = cnt_q + 32'd1;
      end
      ST_BURN: begin
        if (abort) state_d = ST_FAULT;
        else if (burn_end) begin
          if (last_stage)     state_d = ST_DONE;
          else if (underflow) state_d = ST_FAULT;
          else begin
            state_d = ST_SEPARATE;
            cnt_d   = '0;
          end
        end else if (wd_q == WD_W'(MAX_BURN_CYCLES - 1)) state_d = ST_FAULT;
        else wd_d = wd_q + WD_W'(1);
      end
      ST_SEPARATE: begin
        if (abort)         state_d = ST_FAULT;
        else if (sep_last) begin
          state_d = ST_ARM;
          cnt_d   = '0;
        end else           cnt_d = cnt_q + 32'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign load_ops = (state_d == ST_ARM) && (state_q != ST_ARM);

  always_comb begin
    total_d = total_q;
    isp_d   = isp_q;
    initw_d = initw_q;
    prop_d  = prop_q;
    bt_d    = bt_q;
    v0_d    = v0_q;
    fin_d   = fin_q;
    if (launch) begin
      total_d = payload_mass + stack_mass;
      v0_d    = '0;
    end
    if (burn_end) begin
      v0_d  = eng_velocity;
      fin_d = eng_velocity;
      if (!last_stage) total_d = underflow ? '0 : total_q - sep_mass;
    end
    if (load_ops) begin
      isp_d   = rd_rec.isp[W-1:0];
      prop_d  = rd_rec.prop_mass[W-1:0];
      bt_d    = rd_rec.burntime[W-1:0];
      initw_d = total_d;
    end
  end

  always_comb begin
    eng_resetb = (state_q == ST_BURN);
    busy       = (state_q == ST_ARM) || (state_q == ST_BURN) || (state_q == ST_SEPARATE);
    sep_pulse  = (state_q == ST_SEPARATE) && (cnt_q == '0);
    done       = (state_q == ST_DONE);
    fault      = (state_q == ST_FAULT);
  end

  assign eng_isp            = isp_q;
  assign eng_initial_weight = initw_q;
  assign eng_prop_weight    = prop_q;
  assign eng_burntime       = bt_q;
  assign eng_v0             = v0_q;
  assign final_velocity     = fin_q;
  assign stage_idx          = stage_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: flight vectors, randomized flights and corner-case sequences,
// with a toy engine whose burn length and velocity gain follow from its operands.
module tb_stage_sequencer;

  localparam int N    = 3;
  localparam int W    = 64;
  localparam int SEP  = 4;
  localparam int ARM  = 2;
  localparam int MAXB = 100;

  logic         clk = 1'b0;
  logic         resetb = 1'b0;
  logic         start = 1'b0, abort = 1'b0, cfg_we = 1'b0;
  logic [2:0]   cfg_stage = '0;
  logic [1:0]   cfg_field = '0;
  logic [W-1:0] cfg_data = '0, payload_mass = '0;
  logic         eng_resetb, eng_ignition_end, busy, sep_pulse, done, fault;
  logic [W-1:0] eng_isp, eng_initial_weight, eng_prop_weight, eng_burntime, eng_v0;
  logic [W-1:0] eng_velocity, final_velocity;
  logic [2:0]   stage_idx;

  int errors = 0;
  int checks = 0;
  bit hang = 1'b0;
  logic [31:0] eng_cnt = '0;

  stage_sequencer #(
    .N_STAGES(N), .W(W), .SEP_CYCLES(SEP), .ARM_CYCLES(ARM), .MAX_BURN_CYCLES(MAXB)
  ) dut (
    .clk(clk), .resetb(resetb), .start(start), .abort(abort),
    .cfg_we(cfg_we), .cfg_stage(cfg_stage), .cfg_field(cfg_field), .cfg_data(cfg_data),
    .payload_mass(payload_mass), .eng_resetb(eng_resetb), .eng_isp(eng_isp),
    .eng_initial_weight(eng_initial_weight), .eng_prop_weight(eng_prop_weight),
    .eng_burntime(eng_burntime), .eng_v0(eng_v0), .eng_velocity(eng_velocity),
    .eng_ignition_end(eng_ignition_end), .stage_idx(stage_idx), .busy(busy),
    .sep_pulse(sep_pulse), .done(done), .fault(fault), .final_velocity(final_velocity)
  );

  always #5 clk = ~clk;

  // Toy engine: burns burntime+1 cycles out of reset, gains 3*isp+100 on top of v0.
  always @(posedge clk) begin
    if (!eng_resetb) eng_cnt <= '0;
    else             eng_cnt <= eng_cnt + 32'd1;
  end
  assign eng_ignition_end = eng_resetb && !hang && ({32'd0, eng_cnt} >= eng_burntime + 64'd1);
  assign eng_velocity     = eng_v0 + 64'd3 * eng_isp + 64'd100;

  typedef struct packed {
    logic [2:0][63:0] isp;
    logic [2:0][63:0] prop;
    logic [2:0][63:0] dry;
    logic [2:0][63:0] bt;
    logic [63:0]      payload;
    logic [2:0][63:0] exp_w;
  } vec_t;

  vec_t vecs [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_weight(input vec_t v, input int s);
    logic [63:0] w = v.payload;
    for (int j = s; j < N; j++) w = w + v.prop[j] + v.dry[j];
    return w;
  endfunction

  task automatic cfg_write(input logic [2:0] st, input logic [1:0] f, input logic [63:0] d);
    cfg_we = 1'b1; cfg_stage = st; cfg_field = f; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic load_cfg(input vec_t v);
    for (int i = 0; i < N; i++) begin
      cfg_write(3'(i), 2'd0, v.isp[i]);
      cfg_write(3'(i), 2'd1, v.prop[i]);
      cfg_write(3'(i), 2'd2, v.dry[i]);
      cfg_write(3'(i), 2'd3, v.bt[i]);
    end
  endtask

  task automatic pulse_start(input logic [63:0] pm);
    payload_mass = pm; start = 1'b1;
    @(negedge clk);
    start = 1'b0; payload_mass = '1;
  endtask

  task automatic run_flight(input vec_t v, input bit busy_poke, input bit bad_wr);
    logic [63:0] exp_v, fin_snap;
    int s, lowcnt, seps;
    bit prev_rb, fin, v0_bad;
    load_cfg(v);
    if (bad_wr) begin
      cfg_write(3'd5, 2'd0, 64'd777);
      cfg_write(3'd5, 2'd1, 64'd5000);
    end
    pulse_start(v.payload);
    exp_v = '0; s = 0; lowcnt = 0; seps = 0; prev_rb = 1'b0; fin = 1'b0; v0_bad = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin && !fault; cyc++) begin
      cfg_we = 1'b0; start = 1'b0;
      if (sep_pulse) seps++;
      if (eng_resetb && !prev_rb && s < N) begin
        chk("burn_stage", 64'(stage_idx), 64'(s));
        chk("init_weight", eng_initial_weight, v.exp_w[s]);
        chk("isp", eng_isp, v.isp[s]);
        chk("prop", eng_prop_weight, v.prop[s]);
        chk("burntime", eng_burntime, v.bt[s]);
        chk("v0_at_burn", eng_v0, exp_v);
        chk("reset_gap", 64'(lowcnt), 64'((s == 0) ? ARM : SEP + ARM));
        lowcnt = 0;
        if (busy_poke && s == 0) begin
          cfg_we = 1'b1; cfg_stage = 3'd2; cfg_field = 2'd0; cfg_data = 64'd999;
          start = 1'b1;
        end
      end
      if (prev_rb && !eng_resetb && s < N) begin
        exp_v = exp_v + 64'd3 * v.isp[s] + 64'd100;
        s++;
      end
      if (eng_resetb && eng_v0 !== exp_v) v0_bad = 1'b1;
      if (busy && !eng_resetb) lowcnt++;
      if (done) fin = 1'b1;
      prev_rb = eng_resetb;
      if (!fin) @(negedge clk);
    end
    cfg_we = 1'b0; start = 1'b0;
    chk("flight_done", 64'(fin), 64'd1);
    chk("stages_burned", 64'(s), 64'(N));
    chk("sep_count", 64'(seps), 64'(N - 1));
    chk("final_velocity", final_velocity, exp_v);
    chk("v0_stable", 64'(v0_bad), 64'd0);
    chk("busy_in_done", 64'(busy), 64'd0);
    fin_snap = final_velocity;
    repeat (3) @(negedge clk);
    chk("done_hold", 64'(done), 64'd1);
    chk("final_hold", final_velocity, fin_snap);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    int n;
    // Packed lists are written highest index first: {stage2, stage1, stage0}.
    vecs[0].isp = {64'd250, 64'd280, 64'd300};
    vecs[0].prop = {64'd20, 64'd150, 64'd800};
    vecs[0].dry = {64'd5, 64'd30, 64'd100};
    vecs[0].bt = {64'd10, 64'd20, 64'd50};
    vecs[0].payload = 64'd10;
    vecs[0].exp_w = {64'd35, 64'd215, 64'd1115};
    vecs[1].isp = {64'd150, 64'd200, 64'd100};
    vecs[1].prop = {64'd7, 64'd30, 64'd50};
    vecs[1].dry = {64'd3, 64'd5, 64'd10};
    vecs[1].bt = {64'd1, 64'd0, 64'd5};
    vecs[1].payload = 64'd0;
    vecs[1].exp_w = {64'd10, 64'd45, 64'd105};
    vecs[2].isp = {64'd30, 64'd20, 64'd10};
    vecs[2].prop = {64'd3, 64'd2, 64'd1};
    vecs[2].dry = {64'd0, 64'd0, 64'd0};
    vecs[2].bt = {64'd0, 64'd2, 64'd60};
    vecs[2].payload = 64'd1000;
    vecs[2].exp_w = {64'd1003, 64'd1005, 64'd1006};

    #1;
    chk("rst_stage", 64'(stage_idx), 64'd0);
    chk("rst_eng_resetb", 64'(eng_resetb), 64'd0);
    chk("rst_flags", 64'({busy, sep_pulse, done, fault}), 64'd0);
    chk("rst_operands", eng_isp | eng_initial_weight | eng_prop_weight | eng_burntime, 64'd0);
    chk("rst_velocity", eng_v0 | final_velocity, 64'd0);
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) run_flight(vecs[i], i == 0, i == 1);

    // Abort mid-burn on stage 1, then a clean restart from FAULT.
    load_cfg(vecs[0]);
    pulse_start(64'd10);
    n = 0;
    while (!(stage_idx == 3'd1 && eng_resetb) && n < 1000) begin @(negedge clk); n++; end
    chk("reach_stage1_burn", 64'(n < 1000), 64'd1);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_fault", 64'(fault), 64'd1);
    chk("abort_eng_resetb", 64'(eng_resetb), 64'd0);
    chk("abort_stage", 64'(stage_idx), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_final", final_velocity, 64'd1000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_blocks_start", 64'(fault), 64'd1);
    abort = 1'b0;
    run_flight(vecs[0], 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        rv.isp[i]  = 64'($urandom_range(1, 400));
        rv.prop[i] = 64'($urandom_range(1, 1000));
        rv.dry[i]  = 64'($urandom_range(1, 200));
        rv.bt[i]   = 64'($urandom_range(0, 60));
      end
      rv.payload = 64'($urandom_range(0, 500));
      for (int i = 0; i < N; i++) rv.exp_w[i] = model_weight(rv, i);
      run_flight(rv, 1'b0, 1'b0);
    end

    // Hung engine: watchdog must trip exactly MAXB cycles after entering BURN.
    hang = 1'b1;
    pulse_start(64'd10);
    n = 0;
    while (!eng_resetb && n < 50) begin @(negedge clk); n++; end
    chk("watchdog_burn_entry", 64'(n < 50), 64'd1);
    n = 0;
    while (!fault && n < 300) begin @(negedge clk); n++; end
    chk("watchdog_cycles", 64'(n), 64'(MAXB));
    chk("watchdog_stage", 64'(stage_idx), 64'd0);
    chk("watchdog_eng_resetb", 64'(eng_resetb), 64'd0);
    hang = 1'b0;

    // Asynchronous reset while separating, with the clock held low.
    pulse_start(64'd10);
    n = 0;
    while (!sep_pulse && n < 500) begin @(negedge clk); n++; end
    chk("reach_separate", 64'(n < 500), 64'd1);
    #1;
    resetb = 1'b0;
    #1;
    chk("arst_stage", 64'(stage_idx), 64'd0);
    chk("arst_flags", 64'({eng_resetb, busy, sep_pulse, done, fault}), 64'd0);
    chk("arst_operands", eng_isp | eng_initial_weight | eng_prop_weight | eng_burntime, 64'd0);
    chk("arst_velocity", eng_v0 | final_velocity, 64'd0);
    @(negedge clk);
    resetb = 1'b1;
    pulse_start(64'd7);
    chk("arst_table_weight", eng_initial_weight, 64'd7);
    chk("arst_table_isp", eng_isp, 64'd0);
    resetb = 1'b0;
    @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
